// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage core: decodes the ID opcode, carries the
// control bits through ID/EX, EX/MEM and MEM/WB, and handles load-use stalls,
// redirect flushes and a global hold.
module pipe_ctrl_unit #(
   parameter int unsigned REG_ADDR_W       = 5,
   parameter bit          ZERO_RD_SUPPRESS = 1'b1,
   parameter bit          LOAD_USE_EN      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hold,
   input  logic                  id_valid,
   input  logic [6:0]            id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  ex_redirect,
   output logic                  stall_o,
   output logic                  flush_o,
   output logic                  ex_alu_src,
   output logic                  ex_op_a_pc,
   output logic                  ex_branch,
   output logic                  ex_jump,
   output logic                  ex_illegal,
   output logic [1:0]            ex_alu_op,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic                  ex_mem_to_reg,
   output logic                  ex_reg_write,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic                  mem_mem_to_reg,
   output logic                  mem_reg_write,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  wb_mem_to_reg,
   output logic                  wb_reg_write,
   output logic [REG_ADDR_W-1:0] wb_rd
);

   typedef struct packed {
      logic                  alu_src;
      logic                  op_a_pc;
      logic                  branch;
      logic                  jump;
      logic                  illegal;
      logic [1:0]            alu_op;
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
   } ex_ctrl_t;

   typedef struct packed {
      logic                  mem_read;
      logic                  mem_write;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
   } mem_ctrl_t;

   typedef struct packed {
      logic                  mem_to_reg;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rd;
   } wb_ctrl_t;

   ex_ctrl_t  dec;
   ex_ctrl_t  ex_d, ex_q;
   mem_ctrl_t mem_q;
   wb_ctrl_t  wb_q;
   logic      uses_rs1, uses_rs2;
   logic      load_use;
   logic      advance;

   // Decode the ID opcode; an invalid slot decodes as an all-zero bubble.
   always_comb begin
      dec      = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      if (id_valid) begin
         dec.rd = id_rd;
         case (id_opcode)
            7'b0110011: begin
               dec.reg_write = 1'b1;
               dec.alu_op    = 2'b10;
               uses_rs1      = 1'b1;
               uses_rs2      = 1'b1;
            end
            7'b0010011: begin
               dec.alu_src   = 1'b1;
               dec.reg_write = 1'b1;
               dec.alu_op    = 2'b11;
               uses_rs1      = 1'b1;
            end
            7'b0000011: begin
               dec.alu_src    = 1'b1;
               dec.mem_read   = 1'b1;
               dec.mem_to_reg = 1'b1;
               dec.reg_write  = 1'b1;
               uses_rs1       = 1'b1;
            end
            7'b0100011: begin
               dec.alu_src   = 1'b1;
               dec.mem_write = 1'b1;
               uses_rs1      = 1'b1;
               uses_rs2      = 1'b1;
            end
            7'b1100011: begin
               dec.branch = 1'b1;
               dec.alu_op = 2'b01;
               uses_rs1   = 1'b1;
               uses_rs2   = 1'b1;
            end
            7'b0110111: begin
               dec.alu_src   = 1'b1;
               dec.reg_write = 1'b1;
               dec.alu_op    = 2'b11;
            end
            7'b0010111: begin
               dec.alu_src   = 1'b1;
               dec.op_a_pc   = 1'b1;
               dec.reg_write = 1'b1;
            end
            7'b1101111: begin
               dec.jump      = 1'b1;
               dec.op_a_pc   = 1'b1;
               dec.reg_write = 1'b1;
            end
            7'b1100111: begin
               dec.jump      = 1'b1;
               dec.alu_src   = 1'b1;
               dec.reg_write = 1'b1;
               uses_rs1      = 1'b1;
            end
            default: dec.illegal = 1'b1;
         endcase
         if (ZERO_RD_SUPPRESS && (id_rd == '0)) begin
            dec.reg_write = 1'b0;
         end
      end
   end

   // Hazard detection, stall/flush generation and the ID/EX next value.
   always_comb begin
      load_use = LOAD_USE_EN && id_valid && ex_q.mem_read && (ex_q.rd != '0) &&
                 ((uses_rs1 && (ex_q.rd == id_rs1)) || (uses_rs2 && (ex_q.rd == id_rs2)));
      advance  = rst_n & ~hold;
      flush_o  = advance & ex_redirect;
      // Redirect wins: the dependent instruction is on the wrong path anyway.
      stall_o  = advance & ~ex_redirect & load_use;
      ex_d     = (ex_redirect || load_use) ? '0 : dec;
   end

   // Stage registers: synchronous clear, frozen while hold is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!hold) begin
         ex_q  <= ex_d;
         mem_q <= '{mem_read:   ex_q.mem_read,
                    mem_write:  ex_q.mem_write,
                    mem_to_reg: ex_q.mem_to_reg,
                    reg_write:  ex_q.reg_write,
                    rd:         ex_q.rd};
         wb_q  <= '{mem_to_reg: mem_q.mem_to_reg,
                    reg_write:  mem_q.reg_write,
                    rd:         mem_q.rd};
      end
   end

   assign ex_alu_src     = ex_q.alu_src;
   assign ex_op_a_pc     = ex_q.op_a_pc;
   assign ex_branch      = ex_q.branch;
   assign ex_jump        = ex_q.jump;
   assign ex_illegal     = ex_q.illegal;
   assign ex_alu_op      = ex_q.alu_op;
   assign ex_mem_read    = ex_q.mem_read;
   assign ex_mem_write   = ex_q.mem_write;
   assign ex_mem_to_reg  = ex_q.mem_to_reg;
   assign ex_reg_write   = ex_q.reg_write;
   assign ex_rd          = ex_q.rd;
   assign mem_mem_read   = mem_q.mem_read;
   assign mem_mem_write  = mem_q.mem_write;
   assign mem_mem_to_reg = mem_q.mem_to_reg;
   assign mem_reg_write  = mem_q.reg_write;
   assign mem_rd         = mem_q.rd;
   assign wb_mem_to_reg  = wb_q.mem_to_reg;
   assign wb_reg_write   = wb_q.reg_write;
   assign wb_rd          = wb_q.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench: instance 0 uses default parameters, instance 1 has load-use
// detection and x0 suppression disabled. Both see the same stimulus.
module tb_pipe_ctrl_unit;

   typedef struct packed {
      logic       alu_src;
      logic       op_a_pc;
      logic       branch;
      logic       jump;
      logic       illegal;
      logic [1:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic [4:0] rd;
   } st_t;

   typedef struct packed {
      logic stall;
      logic flush;
      st_t  ex;
      st_t  mem;
      st_t  wb;
   } exp_t;

   typedef exp_t [1:0] rec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       hold = 1'b0;
   logic       id_valid = 1'b0;
   logic [6:0] id_opcode = '0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic       ex_redirect = 1'b0;

   logic [1:0] stall_o, flush_o, ex_alu_src, ex_op_a_pc, ex_branch, ex_jump, ex_illegal;
   logic [1:0] ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
   logic [1:0] mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
   logic [1:0] wb_mem_to_reg, wb_reg_write;
   logic [1:0] ex_alu_op [2];
   logic [4:0] ex_rd [2];
   logic [4:0] mem_rd [2];
   logic [4:0] wb_rd [2];

   always #5 clk = ~clk;

   pipe_ctrl_unit u_dut0 (
      .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
      .stall_o(stall_o[0]), .flush_o(flush_o[0]), .ex_alu_src(ex_alu_src[0]),
      .ex_op_a_pc(ex_op_a_pc[0]), .ex_branch(ex_branch[0]), .ex_jump(ex_jump[0]),
      .ex_illegal(ex_illegal[0]), .ex_alu_op(ex_alu_op[0]), .ex_mem_read(ex_mem_read[0]),
      .ex_mem_write(ex_mem_write[0]), .ex_mem_to_reg(ex_mem_to_reg[0]),
      .ex_reg_write(ex_reg_write[0]), .ex_rd(ex_rd[0]), .mem_mem_read(mem_mem_read[0]),
      .mem_mem_write(mem_mem_write[0]), .mem_mem_to_reg(mem_mem_to_reg[0]),
      .mem_reg_write(mem_reg_write[0]), .mem_rd(mem_rd[0]), .wb_mem_to_reg(wb_mem_to_reg[0]),
      .wb_reg_write(wb_reg_write[0]), .wb_rd(wb_rd[0])
   );

   pipe_ctrl_unit #(.REG_ADDR_W(5), .ZERO_RD_SUPPRESS(1'b0), .LOAD_USE_EN(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
      .stall_o(stall_o[1]), .flush_o(flush_o[1]), .ex_alu_src(ex_alu_src[1]),
      .ex_op_a_pc(ex_op_a_pc[1]), .ex_branch(ex_branch[1]), .ex_jump(ex_jump[1]),
      .ex_illegal(ex_illegal[1]), .ex_alu_op(ex_alu_op[1]), .ex_mem_read(ex_mem_read[1]),
      .ex_mem_write(ex_mem_write[1]), .ex_mem_to_reg(ex_mem_to_reg[1]),
      .ex_reg_write(ex_reg_write[1]), .ex_rd(ex_rd[1]), .mem_mem_read(mem_mem_read[1]),
      .mem_mem_write(mem_mem_write[1]), .mem_mem_to_reg(mem_mem_to_reg[1]),
      .mem_reg_write(mem_reg_write[1]), .mem_rd(mem_rd[1]), .wb_mem_to_reg(wb_mem_to_reg[1]),
      .wb_reg_write(wb_reg_write[1]), .wb_rd(wb_rd[1])
   );

   // Reference decode table: opcode -> {alu_src, op_a_pc, branch, jump, mem_read,
   // mem_write, mem_to_reg, reg_write, alu_op[1:0], uses_rs1, uses_rs2}.
   logic [6:0]  tab_opc [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
   logic [11:0] tab_bits [9] = '{12'b0000_0001_10_11, 12'b1000_0001_11_10,
                                 12'b1000_1011_00_10, 12'b1000_0100_00_11,
                                 12'b0010_0000_01_11, 12'b1000_0001_11_00,
                                 12'b1100_0001_00_00, 12'b0101_0001_00_00,
                                 12'b1001_0001_00_10};

   // Model: contents of the EX, MEM and WB slots per instance.
   st_t  m_ex [2];
   st_t  m_mem [2];
   st_t  m_wb [2];
   rec_t sb_q [$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic st_t mem_view(st_t s);
      st_t o = '0;
      o.mem_read = s.mem_read; o.mem_write = s.mem_write;
      o.mem_to_reg = s.mem_to_reg; o.reg_write = s.reg_write; o.rd = s.rd;
      return o;
   endfunction

   function automatic st_t wb_view(st_t s);
      st_t o = '0;
      o.mem_to_reg = s.mem_to_reg; o.reg_write = s.reg_write; o.rd = s.rd;
      return o;
   endfunction

   task automatic model_step(input int k, input logic v, input logic [6:0] opc,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic redir, input logic hld, input logic rstn,
                             output exp_t e);
      st_t  d = '0;
      logic u1 = 1'b0, u2 = 1'b0, found = 1'b0, haz;
      e = '0;
      if (!rstn) begin
         m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
      end else if (!hld) begin
         if (v) begin
            d.rd = rd;
            for (int i = 0; i < 9; i++) begin
               if (tab_opc[i] == opc) begin
                  found = 1'b1;
                  {d.alu_src, d.op_a_pc, d.branch, d.jump, d.mem_read, d.mem_write,
                   d.mem_to_reg, d.reg_write, d.alu_op, u1, u2} = tab_bits[i];
               end
            end
            if (!found) d.illegal = 1'b1;
            if (k == 0 && rd == 0) d.reg_write = 1'b0;
         end
         haz = (k == 0) && v && m_ex[k].mem_read && (m_ex[k].rd != 0) &&
               ((u1 && rs1 == m_ex[k].rd) || (u2 && rs2 == m_ex[k].rd));
         e.flush  = redir;
         e.stall  = haz && !redir;
         m_wb[k]  = m_mem[k];
         m_mem[k] = m_ex[k];
         m_ex[k]  = (redir || haz) ? st_t'('0) : d;
      end
      e.ex  = m_ex[k];
      e.mem = mem_view(m_mem[k]);
      e.wb  = wb_view(m_wb[k]);
   endtask

   // One clock of stimulus; returns whether instance 0 is expected to stall.
   task automatic issue(input logic v, input logic [6:0] opc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic redir,
                        input logic hld, input logic rstn, output logic stalled);
      rec_t r;
      @(negedge clk);
      id_valid = v; id_opcode = opc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      ex_redirect = redir; hold = hld; rst_n = rstn;
      for (int k = 0; k < 2; k++) model_step(k, v, opc, rs1, rs2, rd, redir, hld, rstn, r[k]);
      sb_q.push_back(r);
      stalled = r[0].stall;
   endtask

   // Issue an instruction, re-presenting it while IF/ID is held by a stall.
   task automatic instr(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic redir = 1'b0);
      logic st;
      for (int n = 0; n < 4; n++) begin
         issue(1'b1, opc, rs1, rs2, rd, (n == 0) ? redir : 1'b0, 1'b0, 1'b1, st);
         if (!st) break;
      end
   endtask

   function automatic st_t obs_ex(int k);
      st_t o;
      o = '{alu_src: ex_alu_src[k], op_a_pc: ex_op_a_pc[k], branch: ex_branch[k],
            jump: ex_jump[k], illegal: ex_illegal[k], alu_op: ex_alu_op[k],
            mem_read: ex_mem_read[k], mem_write: ex_mem_write[k],
            mem_to_reg: ex_mem_to_reg[k], reg_write: ex_reg_write[k], rd: ex_rd[k]};
      return o;
   endfunction

   function automatic st_t obs_mem(int k);
      st_t o = '0;
      o.mem_read = mem_mem_read[k]; o.mem_write = mem_mem_write[k];
      o.mem_to_reg = mem_mem_to_reg[k]; o.reg_write = mem_reg_write[k]; o.rd = mem_rd[k];
      return o;
   endfunction

   function automatic st_t obs_wb(int k);
      st_t o = '0;
      o.mem_to_reg = wb_mem_to_reg[k]; o.reg_write = wb_reg_write[k]; o.rd = wb_rd[k];
      return o;
   endfunction

   task automatic chk(input string name, input int k, input logic [15:0] act,
                      input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
   initial begin
      rec_t r;
      forever begin
         @(negedge clk);
         #2;
         if (sb_q.size() != 0) begin
            r = sb_q.pop_front();
            for (int k = 0; k < 2; k++) begin
               chk("stall_o", k, 16'(stall_o[k]), 16'(r[k].stall));
               chk("flush_o", k, 16'(flush_o[k]), 16'(r[k].flush));
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
               chk("ex_ctrl", k, obs_ex(k), r[k].ex);
               chk("mem_ctrl", k, obs_mem(k), r[k].mem);
               chk("wb_ctrl", k, obs_wb(k), r[k].wb);
            end
         end
      end
   end

   initial begin
      logic       st, v, redir, hld, rstn;
      logic [6:0] opc;
      logic [4:0] rs1, rs2, rd;
      for (int k = 0; k < 2; k++) begin
         m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0;
      end
      // Reset with R-type traffic present, then add x3 flowing to WB.
      repeat (2) issue(1'b1, 7'b0110011, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, st);
      instr(7'b0110011, 5'd1, 5'd2, 5'd3);
      repeat (3) issue(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, st);
      // Load-use: lw x5 then add x6,x5,x1.
      instr(7'b0000011, 5'd2, 5'd0, 5'd5);
      instr(7'b0110011, 5'd5, 5'd1, 5'd6);
      // lw x0 then add using x0; lw x7 then LUI x7.
      instr(7'b0000011, 5'd2, 5'd0, 5'd0);
      instr(7'b0110011, 5'd0, 5'd0, 5'd4);
      instr(7'b0000011, 5'd2, 5'd0, 5'd7);
      instr(7'b0110111, 5'd7, 5'd7, 5'd7);
      // Redirect in the same cycle as a load-use hazard.
      instr(7'b0000011, 5'd2, 5'd0, 5'd5);
      instr(7'b0110011, 5'd5, 5'd5, 5'd6, 1'b1);
      // Hold for three cycles mid-stream.
      instr(7'b0010011, 5'd1, 5'd0, 5'd8);
      instr(7'b0100011, 5'd8, 5'd9, 5'd0);
      repeat (3) issue(1'b1, 7'b1100011, 5'd8, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, st);
      instr(7'b1100011, 5'd8, 5'd9, 5'd0);
      // Illegal opcode and JAL, then JALR / AUIPC.
      instr(7'b1111111, 5'd1, 5'd2, 5'd3);
      instr(7'b1101111, 5'd0, 5'd0, 5'd1);
      instr(7'b1100111, 5'd1, 5'd0, 5'd1);
      instr(7'b0010111, 5'd0, 5'd0, 5'd2);
      repeat (3) issue(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1, st);
      // Randomised traffic; a stalled instruction is re-presented unchanged.
      st = 1'b0;
      opc = '0; rs1 = '0; rs2 = '0; rd = '0; v = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!st) begin
            v   = ($urandom_range(0, 9) != 0);
            opc = ($urandom_range(0, 7) != 0) ? tab_opc[$urandom_range(0, 8)]
                                              : 7'($urandom);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
         end
         redir = ($urandom_range(0, 9) == 0);
         hld   = ($urandom_range(0, 11) == 0);
         rstn  = ($urandom_range(0, 49) != 0);
         issue(v, opc, rs1, rs2, rd, redir, hld, rstn, st);
      end
      repeat (3) @(posedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 5-stage RISC-V core: it decodes the ID-stage opcode into control bits and carries them through ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and injects bubbles, and flushes wrong-path instructions when EX redirects the PC. Compared with the previous single-cycle combinational decoder, it adds separate jump and PC-operand controls, illegal-opcode flagging, x0-write suppression and a global pipeline hold. It sits beside the datapath pipeline registers and drives the IF/ID stall/flush controls.

## Interface
Parameters
- REG_ADDR_W, 5, register-index width
- ZERO_RD_SUPPRESS, 1, 1: force reg_write=0 when rd==0
- LOAD_USE_EN, 1, 1: detect load-use hazards; 0: stall_o tied 0

Ports
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low. One clock; all state is sampled on the rising edge of clk.
- hold  in  1  global freeze (memory wait); no pipeline register updates
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  7  opcode of ID instruction
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  ID register indices
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle
- stall_o  out  1  hold PC and IF/ID (combinational)
- flush_o  out  1  kill IF/ID contents (combinational, = ex_redirect & ~hold)
- ex_alu_src, ex_op_a_pc, ex_branch, ex_jump, ex_illegal  out  1 each  EX controls
- ex_alu_op  out  2  ALU control class
- ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1 each  controls in EX
- ex_rd  out  REG_ADDR_W
- mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write  out  1 each
- mem_rd  out  REG_ADDR_W
- wb_mem_to_reg, wb_reg_write  out  1 each
- wb_rd  out  REG_ADDR_W

## Operation
- Decode (combinational, ID). Listed bits are 1; all others are 0:
  - 0110011: reg_write, alu_op=10
  - 0010011: alu_src, reg_write, alu_op=11
  - 0000011: alu_src, mem_read, mem_to_reg, reg_write, alu_op=00
  - 0100011: alu_src, mem_write, alu_op=00
  - 1100011: branch, alu_op=01
  - 0110111 (LUI): alu_src, reg_write, alu_op=11
  - 0010111 (AUIPC): alu_src, op_a_pc, reg_write, alu_op=00
  - 1101111 (JAL): jump, op_a_pc, reg_write, alu_op=00
  - 1100111 (JALR): jump, alu_src, reg_write, alu_op=00
  - any other opcode with id_valid=1: illegal=1, all other bits 0
- Source use: uses_rs1 for R, I-arith, load, store, branch, JALR. uses_rs2 for R, store, branch.
- Load-use hazard: ex_mem_read & ex_rd!=0 & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)) & id_valid & LOAD_USE_EN.
- id_valid=0 decodes as an all-zero bubble.
- When ZERO_RD_SUPPRESS=1, the decoded reg_write is cleared when id_rd==0.
- Per-edge update priority:
  1. ~rst_n: all stage registers cleared.
  2. hold: all registers keep their value; stall_o=0 and flush_o=0.
  3. ex_redirect: the ID/EX register loads a bubble; EX->MEM and MEM->WB advance normally. A simultaneous hazard is ignored.
  4. Hazard: the ID/EX register loads a bubble; stall_o=1; MEM and WB advance.
  5. Otherwise: the ID/EX register loads the decoded bits and id_rd; MEM loads from EX; WB loads from MEM.
- A bubble is all control bits 0 and rd=0. It never writes memory or registers.

## Timing
- Reset: every ex_/mem_/wb_ output is 0 on the first edge with rst_n=0. stall_o=0 and flush_o=0 while rst_n=0.
- Latency from ID: EX controls valid at +1 cycle, MEM at +2, WB at +3.
- A load-use hazard produces exactly one stall cycle. On the next cycle the load is in MEM, so the condition clears and the dependent instruction enters EX.
- stall_o and flush_o are combinational within the same cycle. There is no registered handshake.
- A reset asserted mid-operation discards all in-flight controls within one edge.
- A hold lasting N cycles delays all outputs by N cycles with no loss and no duplication.

## Test plan
- Reset: drive rst_n=0 with valid R-type traffic -> all ex_/mem_/wb_ outputs are 0 after the edge; after release, add x3 (0110011, rd=3) shows ex_reg_write=1 and ex_alu_op=10 at +1, then wb_reg_write=1 and wb_rd=3 at +3.
- Load-use: lw x5 followed by add x6,x5,x1 -> stall_o=1 for exactly one cycle and one all-zero EX bubble; add reaches EX one cycle later. Repeat with LOAD_USE_EN=0 -> stall_o stays 0.
- x0 and non-use: lw x0 followed by add using x0 -> no stall, and ex_reg_write=0 for the load. LUI x7 after lw x7 -> no stall, because LUI has no rs1 use.
- Redirect priority: ex_redirect=1 in the same cycle as a load-use hazard -> flush_o=1, stall_o=0, ID/EX loads a bubble, and the older load advances to MEM.
- Hold: hold=1 for 3 cycles in mid-stream -> all outputs frozen and stall_o=0/flush_o=0 during hold; the sequence resumes unchanged.
- Illegal/JAL: opcode 1111111 -> ex_illegal=1 and all other EX bits 0. JAL (1101111) -> ex_jump=1, ex_op_a_pc=1, ex_branch=0.
